// File: rtl/dcache_victim_ctrl.sv
// Dcache miss controller: probes the victim cache, refills from it or from memory,
// and pushes the displaced line into the victim cache. Optional counters: VICTIM_STATS_EN.
module dcache_victim_ctrl #(
  parameter int DCACHE_LINE_WIDTH = 128,
  parameter int VICTIM_ADDR_BITS  = 28
`ifdef VICTIM_STATS_EN
  ,parameter int STAT_CNT_BITS    = 32
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss_req_i,
  input  logic [VICTIM_ADDR_BITS-1:0]  miss_addr_i,
  input  logic                         evict_valid_i,
  input  logic [VICTIM_ADDR_BITS-1:0]  evict_addr_i,
  input  logic [DCACHE_LINE_WIDTH-1:0] evict_data_i,
  output logic [VICTIM_ADDR_BITS-1:0]  cache_to_victim_addr_o,
  output logic [DCACHE_LINE_WIDTH-1:0] cache_to_victim_data_o,
  output logic                         write_to_victim_o,
  input  logic [DCACHE_LINE_WIDTH-1:0] victim_to_cache_data_i,
  input  logic                         victim_hit_i,
  output logic                         mem_req_o,
  output logic [VICTIM_ADDR_BITS-1:0]  mem_addr_o,
  input  logic                         mem_ack_i,
  input  logic [DCACHE_LINE_WIDTH-1:0] mem_data_i,
  output logic                         busy_o,
  output logic                         fill_valid_o,
  output logic [VICTIM_ADDR_BITS-1:0]  fill_addr_o,
  output logic [DCACHE_LINE_WIDTH-1:0] fill_data_o,
  output logic                         fill_from_victim_o
`ifdef VICTIM_STATS_EN
  ,output logic [STAT_CNT_BITS-1:0]    victim_hit_cnt_o
  ,output logic [STAT_CNT_BITS-1:0]    victim_miss_cnt_o
`endif
);

  // state | meaning
  // IDLE  | waiting for a dcache miss
  // PROBE | victim lookup on the captured miss address
  // MEM   | memory read outstanding, waiting for ack
  // FILL  | refill pulse to dcache, optional victim write of evicted line
  typedef enum logic [1:0] {IDLE, PROBE, MEM, FILL} state_t;

  state_t                         state_q, state_d;
  logic [VICTIM_ADDR_BITS-1:0]    miss_addr_q, miss_addr_d;
  logic                           evict_valid_q, evict_valid_d;
  logic [VICTIM_ADDR_BITS-1:0]    evict_addr_q, evict_addr_d;
  logic [DCACHE_LINE_WIDTH-1:0]   evict_data_q, evict_data_d;
  logic [DCACHE_LINE_WIDTH-1:0]   line_q, line_d;
  logic                           src_q, src_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      miss_addr_q   <= '0;
      evict_valid_q <= 1'b0;
      evict_addr_q  <= '0;
      evict_data_q  <= '0;
      line_q        <= '0;
      src_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      miss_addr_q   <= miss_addr_d;
      evict_valid_q <= evict_valid_d;
      evict_addr_q  <= evict_addr_d;
      evict_data_q  <= evict_data_d;
      line_q        <= line_d;
      src_q         <= src_d;
    end
  end

  always_comb begin
    state_d                = state_q;
    miss_addr_d            = miss_addr_q;
    evict_valid_d          = evict_valid_q;
    evict_addr_d           = evict_addr_q;
    evict_data_d           = evict_data_q;
    line_d                 = line_q;
    src_d                  = src_q;
    cache_to_victim_addr_o = '0;
    cache_to_victim_data_o = '0;
    write_to_victim_o      = 1'b0;
    mem_req_o              = 1'b0;
    mem_addr_o             = '0;
    fill_valid_o           = 1'b0;
    fill_addr_o            = '0;
    fill_data_o            = '0;
    fill_from_victim_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_req_i) begin
          miss_addr_d   = miss_addr_i;
          evict_valid_d = evict_valid_i;
          evict_addr_d  = evict_addr_i;
          evict_data_d  = evict_data_i;
          state_d       = PROBE;
        end
      end
      PROBE: begin
        cache_to_victim_addr_o = miss_addr_q;
        if (victim_hit_i) begin
          line_d  = victim_to_cache_data_i;
          src_d   = 1'b1;
          state_d = FILL;
        end else begin
          state_d = MEM;
        end
      end
      MEM: begin
        mem_req_o  = 1'b1;
        mem_addr_o = miss_addr_q;
        if (mem_ack_i) begin
          line_d  = mem_data_i;
          src_d   = 1'b0;
          state_d = FILL;
        end
      end
      FILL: begin
        fill_valid_o       = 1'b1;
        fill_addr_o        = miss_addr_q;
        fill_data_o        = line_q;
        fill_from_victim_o = src_q;
        // displaced line goes to the victim cache even if it aliases the miss address
        if (evict_valid_q) begin
          write_to_victim_o      = 1'b1;
          cache_to_victim_addr_o = evict_addr_q;
          cache_to_victim_data_o = evict_data_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

`ifdef VICTIM_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      victim_hit_cnt_o  <= '0;
      victim_miss_cnt_o <= '0;
    end else if (state_q == PROBE) begin
      if (victim_hit_i) begin
        if (victim_hit_cnt_o != '1) victim_hit_cnt_o <= victim_hit_cnt_o + 1'b1;
      end else begin
        if (victim_miss_cnt_o != '1) victim_miss_cnt_o <= victim_miss_cnt_o + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_victim_ctrl.sv
// Directed bench for dcache_victim_ctrl: victim hit, memory refill, no-evict refill,
// request during MEM, back-to-back accept and reset while in MEM.
module tb_dcache_victim_ctrl;
  localparam int LW  = 128;
  localparam int VAB = 28;

  logic           clk;
  logic           rst;
  logic           miss_req_i;
  logic [VAB-1:0] miss_addr_i;
  logic           evict_valid_i;
  logic [VAB-1:0] evict_addr_i;
  logic [LW-1:0]  evict_data_i;
  logic [VAB-1:0] cache_to_victim_addr_o;
  logic [LW-1:0]  cache_to_victim_data_o;
  logic           write_to_victim_o;
  logic [LW-1:0]  victim_to_cache_data_i;
  logic           victim_hit_i;
  logic           mem_req_o;
  logic [VAB-1:0] mem_addr_o;
  logic           mem_ack_i;
  logic [LW-1:0]  mem_data_i;
  logic           busy_o;
  logic           fill_valid_o;
  logic [VAB-1:0] fill_addr_o;
  logic [LW-1:0]  fill_data_o;
  logic           fill_from_victim_o;
`ifdef VICTIM_STATS_EN
  logic [31:0]    victim_hit_cnt_o;
  logic [31:0]    victim_miss_cnt_o;
`endif

  localparam logic [LW-1:0] DATA_A  = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [LW-1:0] DATA_B  = 128'hBBBB_1111_BBBB_2222_BBBB_3333_BBBB_4444;
  localparam logic [LW-1:0] DATA_C  = 128'hCCCC_5555_CCCC_6666_CCCC_7777_CCCC_8888;
  localparam logic [LW-1:0] EVICT_1 = 128'hE1E1_0000_E1E1_0000_E1E1_0000_E1E1_0001;
  localparam logic [LW-1:0] EVICT_2 = 128'hE2E2_0000_E2E2_0000_E2E2_0000_E2E2_0002;

  int n_cmp = 0;
  int n_err = 0;
  int req_cycles;

  dcache_victim_ctrl dut (
    .clk                    (clk),
    .rst                    (rst),
    .miss_req_i             (miss_req_i),
    .miss_addr_i            (miss_addr_i),
    .evict_valid_i          (evict_valid_i),
    .evict_addr_i           (evict_addr_i),
    .evict_data_i           (evict_data_i),
    .cache_to_victim_addr_o (cache_to_victim_addr_o),
    .cache_to_victim_data_o (cache_to_victim_data_o),
    .write_to_victim_o      (write_to_victim_o),
    .victim_to_cache_data_i (victim_to_cache_data_i),
    .victim_hit_i           (victim_hit_i),
    .mem_req_o              (mem_req_o),
    .mem_addr_o             (mem_addr_o),
    .mem_ack_i              (mem_ack_i),
    .mem_data_i             (mem_data_i),
    .busy_o                 (busy_o),
    .fill_valid_o           (fill_valid_o),
    .fill_addr_o            (fill_addr_o),
    .fill_data_o            (fill_data_o),
    .fill_from_victim_o     (fill_from_victim_o)
`ifdef VICTIM_STATS_EN
    ,.victim_hit_cnt_o      (victim_hit_cnt_o)
    ,.victim_miss_cnt_o     (victim_miss_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_fill"},  128'(fill_valid_o), 128'(0));
    chk({tag, "_wr"},    128'(write_to_victim_o), 128'(0));
  endtask

  initial begin
    rst = 1'b0;
    miss_req_i = 1'b0; miss_addr_i = '0;
    evict_valid_i = 1'b0; evict_addr_i = '0; evict_data_i = '0;
    victim_to_cache_data_i = '0; victim_hit_i = 1'b0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    step();
    step();
    chk("rst_busy",  128'(busy_o), 128'(0));
    chk("rst_mreq",  128'(mem_req_o), 128'(0));
    chk("rst_vaddr", 128'(cache_to_victim_addr_o), 128'(0));
    check_quiet("rst");
    rst = 1'b1;

    // victim hit with eviction
    miss_req_i = 1'b1; miss_addr_i = 28'h0000123;
    evict_valid_i = 1'b1; evict_addr_i = 28'h0000456; evict_data_i = EVICT_1;
    victim_hit_i = 1'b1; victim_to_cache_data_i = DATA_A;
    step();
    miss_req_i = 1'b0; miss_addr_i = 28'h0FFFFFF; evict_addr_i = 28'h0EEEEEE; evict_data_i = '1;
    chk("hit_probe_busy",  128'(busy_o), 128'(1));
    chk("hit_probe_vaddr", 128'(cache_to_victim_addr_o), 128'(28'h0000123));
    check_quiet("hit_probe");
    step();
    victim_hit_i = 1'b0; victim_to_cache_data_i = '0;
    chk("hit_fill_valid", 128'(fill_valid_o), 128'(1));
    chk("hit_fill_addr",  128'(fill_addr_o), 128'(28'h0000123));
    chk("hit_fill_data",  fill_data_o, DATA_A);
    chk("hit_fill_src",   128'(fill_from_victim_o), 128'(1));
    chk("hit_wr",         128'(write_to_victim_o), 128'(1));
    chk("hit_wr_addr",    128'(cache_to_victim_addr_o), 128'(28'h0000456));
    chk("hit_wr_data",    cache_to_victim_data_o, EVICT_1);
    chk("hit_mreq",       128'(mem_req_o), 128'(0));
    step();
    chk("hit_idle_busy",  128'(busy_o), 128'(0));
    check_quiet("hit_idle");

    // victim miss, ack during the 5th MEM cycle, miss_req toggled while busy
    miss_req_i = 1'b1; miss_addr_i = 28'h0000ABC;
    evict_valid_i = 1'b1; evict_addr_i = 28'h0000789; evict_data_i = EVICT_2;
    step();
    miss_req_i = 1'b0; miss_addr_i = 28'h0000111;
    chk("miss_probe_vaddr", 128'(cache_to_victim_addr_o), 128'(28'h0000ABC));
    step();
    req_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req_o) req_cycles++;
      chk("miss_mem_addr", 128'(mem_addr_o), 128'(28'h0000ABC));
      chk("miss_mem_busy", 128'(busy_o), 128'(1));
      chk("miss_mem_fill", 128'(fill_valid_o), 128'(0));
      miss_req_i = ~miss_req_i;
      if (i == 4) begin
        mem_ack_i = 1'b1; mem_data_i = DATA_B;
      end
      step();
    end
    mem_ack_i = 1'b0; mem_data_i = '0;
    chk("miss_req_cycles", 128'(req_cycles), 128'(5));
    chk("miss_fill_valid", 128'(fill_valid_o), 128'(1));
    chk("miss_fill_addr",  128'(fill_addr_o), 128'(28'h0000ABC));
    chk("miss_fill_data",  fill_data_o, DATA_B);
    chk("miss_fill_src",   128'(fill_from_victim_o), 128'(0));
    chk("miss_wr",         128'(write_to_victim_o), 128'(1));
    chk("miss_wr_addr",    128'(cache_to_victim_addr_o), 128'(28'h0000789));
    chk("miss_mreq_drop",  128'(mem_req_o), 128'(0));

    // next request held from the FILL cycle: accepted in the following IDLE cycle
    miss_req_i = 1'b1; miss_addr_i = 28'h0000321;
    evict_valid_i = 1'b0; evict_addr_i = 28'h0000999; evict_data_i = EVICT_1;
    step();
    chk("b2b_idle_busy", 128'(busy_o), 128'(0));
    check_quiet("b2b_idle");
    step();
    miss_req_i = 1'b0;
    chk("b2b_probe_busy",  128'(busy_o), 128'(1));
    chk("b2b_probe_vaddr", 128'(cache_to_victim_addr_o), 128'(28'h0000321));
    step();
    chk("noev_mem_req", 128'(mem_req_o), 128'(1));
    check_quiet("noev_mem0");
    mem_ack_i = 1'b1; mem_data_i = DATA_C;
    step();
    mem_ack_i = 1'b0; mem_data_i = '0;
    chk("noev_fill_valid", 128'(fill_valid_o), 128'(1));
    chk("noev_fill_data",  fill_data_o, DATA_C);
    chk("noev_fill_addr",  128'(fill_addr_o), 128'(28'h0000321));
    chk("noev_wr",         128'(write_to_victim_o), 128'(0));
    chk("noev_wr_addr",    128'(cache_to_victim_addr_o), 128'(0));
    chk("noev_wr_data",    cache_to_victim_data_o, 128'(0));
    step();
    check_quiet("noev_idle");

    // reset while waiting in MEM, late ack ignored
    miss_req_i = 1'b1; miss_addr_i = 28'h0000555;
    evict_valid_i = 1'b1; evict_addr_i = 28'h0000666;
    step();
    miss_req_i = 1'b0;
    step();
    chk("rmem_req", 128'(mem_req_o), 128'(1));
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rmem_busy", 128'(busy_o), 128'(0));
    chk("rmem_mreq", 128'(mem_req_o), 128'(0));
    check_quiet("rmem_after");
    mem_ack_i = 1'b1; mem_data_i = DATA_A;
    step();
    mem_ack_i = 1'b0;
    chk("rmem_late_busy", 128'(busy_o), 128'(0));
    check_quiet("rmem_late");
    step();
    check_quiet("rmem_late2");

`ifdef VICTIM_STATS_EN
    // reset cleared the counts; the MEM-reset request counted a miss before it
    chk("stat_hit",  128'(victim_hit_cnt_o), 128'(0));
    chk("stat_miss", 128'(victim_miss_cnt_o), 128'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
